// File: rtl/ahb_lite_arbiter_pkg.sv
// Shared encodings for the two-master AHB-Lite arbiter: FSM states,
// data-phase owner, HTRANS codes and the default hold limit.
package ahb_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } arb_state_t;

  typedef enum logic [1:0] {
    OWNER_NONE = 2'd0,
    OWNER_M0   = 2'd1,
    OWNER_M1   = 2'd2
  } owner_t;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  localparam int MAX_HOLD_DEFAULT = 4;

endpackage

// File: rtl/ahb_lite_arbiter_if.sv
// Bus bundle between two AHB-Lite masters, the arbiter and one slave.
// The slave modport is the arbiter's view; master is the environment's.
interface ahb_lite_arbiter_if;

  logic        M0_REQ;
  logic        M1_REQ;
  logic [31:0] M0_HADDR;
  logic [31:0] M1_HADDR;
  logic        M0_HWRITE;
  logic        M1_HWRITE;
  logic [31:0] M0_HWDATA;
  logic [31:0] M1_HWDATA;
  logic        M0_GNT;
  logic        M1_GNT;
  logic        M0_HREADY;
  logic        M1_HREADY;
  logic [31:0] HADDR;
  logic        HWRITE;
  logic [1:0]  HTRANS;
  logic [31:0] HWDATA;
  logic        HREADY;

  modport slave (
    input  M0_REQ, M1_REQ, M0_HADDR, M1_HADDR, M0_HWRITE, M1_HWRITE,
    input  M0_HWDATA, M1_HWDATA, HREADY,
    output M0_GNT, M1_GNT, M0_HREADY, M1_HREADY,
    output HADDR, HWRITE, HTRANS, HWDATA
  );

  modport master (
    output M0_REQ, M1_REQ, M0_HADDR, M1_HADDR, M0_HWRITE, M1_HWRITE,
    output M0_HWDATA, M1_HWDATA, HREADY,
    input  M0_GNT, M1_GNT, M0_HREADY, M1_HREADY,
    input  HADDR, HWRITE, HTRANS, HWDATA
  );

endinterface

// File: rtl/ahb_arb_rr.sv
// Round-robin tie-break and hold-limit decision for the two-master arbiter.
// Purely combinational; the FSM in the top level consumes both flags.
module ahb_arb_rr
  import ahb_arb_pkg::*;
#(
  parameter int MAX_HOLD = MAX_HOLD_DEFAULT
) (
  input  logic       rr_ptr,
  input  logic [3:0] hold_cnt,
  output logic       tie_m1,
  output logic       hold_done
);

  // The transfer completing at this edge is the MAX_HOLD-th one when the
  // counter already shows MAX_HOLD-1.
  localparam logic [4:0] HOLD_LAST = 5'(MAX_HOLD - 1);

  assign tie_m1    = ~rr_ptr;
  assign hold_done = ({1'b0, hold_cnt} >= HOLD_LAST);

endmodule

// File: rtl/ahb_lite_arbiter.sv
// Two-master AHB-Lite arbiter: registered grant FSM with round-robin and
// hold limit, combinational address mux, registered data-phase owner mux.
module ahb_lite_arbiter
  import ahb_arb_pkg::*;
#(
  parameter int MAX_HOLD = MAX_HOLD_DEFAULT
) (
  input  logic              HCLK,
  input  logic              HRESET,
  ahb_lite_arbiter_if.slave bus
);

  arb_state_t  state_reg, state_next;
  logic [3:0]  hold_reg, hold_next;
  logic        rr_reg, rr_next;
  owner_t      owner_reg, owner_next;
  logic        tie_m1;
  logic        hold_done;
  logic        xfer0;
  logic        xfer1;
  logic [31:0] haddr_mux;
  logic        hwrite_mux;
  logic [1:0]  htrans_mux;
  logic [31:0] hwdata_mux;

  ahb_arb_rr #(.MAX_HOLD(MAX_HOLD)) u_rr (
    .rr_ptr    (rr_reg),
    .hold_cnt  (hold_reg),
    .tie_m1    (tie_m1),
    .hold_done (hold_done)
  );

  assign xfer0 = (state_reg == ST_OWN0) && bus.M0_REQ;
  assign xfer1 = (state_reg == ST_OWN1) && bus.M1_REQ;

  // Reset wins over a stalled slave so an in-flight data phase is dropped.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_reg <= ST_IDLE;
      hold_reg  <= 4'd0;
      rr_reg    <= 1'b1;
      owner_reg <= OWNER_NONE;
    end else if (bus.HREADY) begin
      state_reg <= state_next;
      hold_reg  <= hold_next;
      rr_reg    <= rr_next;
      owner_reg <= owner_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (bus.M0_REQ && bus.M1_REQ) state_next = tie_m1 ? ST_OWN1 : ST_OWN0;
        else if (bus.M0_REQ)          state_next = ST_OWN0;
        else if (bus.M1_REQ)          state_next = ST_OWN1;
      end
      ST_OWN0: begin
        if (!bus.M0_REQ)                 state_next = bus.M1_REQ ? ST_OWN1 : ST_IDLE;
        else if (bus.M1_REQ && hold_done) state_next = ST_OWN1;
      end
      ST_OWN1: begin
        if (!bus.M1_REQ)                 state_next = bus.M0_REQ ? ST_OWN0 : ST_IDLE;
        else if (bus.M0_REQ && hold_done) state_next = ST_OWN0;
      end
      default: state_next = ST_IDLE;
    endcase

    // Saturate so a long uncontested tenure cannot wrap into a false limit.
    hold_next = hold_reg;
    if (state_next != state_reg)                 hold_next = 4'd0;
    else if ((xfer0 || xfer1) && hold_reg != 4'hF) hold_next = hold_reg + 4'd1;

    rr_next = rr_reg;
    if (state_next == ST_OWN0 && state_reg != ST_OWN0) rr_next = 1'b0;
    if (state_next == ST_OWN1 && state_reg != ST_OWN1) rr_next = 1'b1;

    owner_next = OWNER_NONE;
    if (xfer0)      owner_next = OWNER_M0;
    else if (xfer1) owner_next = OWNER_M1;
  end

  always_comb begin
    haddr_mux  = 32'd0;
    hwrite_mux = 1'b0;
    htrans_mux = HTRANS_IDLE;
    if (xfer0) begin
      haddr_mux  = bus.M0_HADDR;
      hwrite_mux = bus.M0_HWRITE;
      htrans_mux = HTRANS_NONSEQ;
    end else if (xfer1) begin
      haddr_mux  = bus.M1_HADDR;
      hwrite_mux = bus.M1_HWRITE;
      htrans_mux = HTRANS_NONSEQ;
    end

    case (owner_reg)
      OWNER_M0: hwdata_mux = bus.M0_HWDATA;
      OWNER_M1: hwdata_mux = bus.M1_HWDATA;
      default:  hwdata_mux = 32'd0;
    endcase
  end

  assign bus.M0_GNT    = (state_reg == ST_OWN0);
  assign bus.M1_GNT    = (state_reg == ST_OWN1);
  assign bus.M0_HREADY = bus.HREADY;
  assign bus.M1_HREADY = bus.HREADY;
  assign bus.HADDR     = haddr_mux;
  assign bus.HWRITE    = hwrite_mux;
  assign bus.HTRANS    = htrans_mux;
  assign bus.HWDATA    = hwdata_mux;

endmodule

// File: tb/tb_ahb_lite_arbiter.sv
// Scenario bench for ahb_lite_arbiter: each cycle's expected outputs are
// queued as the stimulus is driven and compared at the following negedge.
module tb_ahb_lite_arbiter;

  logic HCLK;
  logic HRESET;

  ahb_lite_arbiter_if bus ();

  ahb_lite_arbiter #(.MAX_HOLD(4)) dut (
    .HCLK   (HCLK),
    .HRESET (HRESET),
    .bus    (bus)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  typedef struct packed {
    logic        gnt0;
    logic        gnt1;
    logic        rdy0;
    logic        rdy1;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [31:0] haddr;
    logic [31:0] hwdata;
  } obs_t;

  obs_t sb[$];
  obs_t obs;
  obs_t ex;
  int   checks = 0;
  int   errors = 0;

  function automatic obs_t mk(input logic g0, input logic g1, input logic rdy,
                              input logic [1:0] tr, input logic w,
                              input logic [31:0] a, input logic [31:0] d);
    obs_t o;
    o.gnt0 = g0; o.gnt1 = g1; o.rdy0 = rdy; o.rdy1 = rdy;
    o.htrans = tr; o.hwrite = w; o.haddr = a; o.hwdata = d;
    return o;
  endfunction

  function automatic obs_t sample();
    obs_t o;
    o.gnt0 = bus.M0_GNT; o.gnt1 = bus.M1_GNT;
    o.rdy0 = bus.M0_HREADY; o.rdy1 = bus.M1_HREADY;
    o.htrans = bus.HTRANS; o.hwrite = bus.HWRITE;
    o.haddr = bus.HADDR; o.hwdata = bus.HWDATA;
    return o;
  endfunction

  function automatic string fmt(input obs_t o);
    return $sformatf("gnt=%b%b rdy=%b%b tr=%b w=%b a=%h d=%h",
                     o.gnt0, o.gnt1, o.rdy0, o.rdy1, o.htrans, o.hwrite, o.haddr, o.hwdata);
  endfunction

  // One bus cycle of stimulus, applied just after the rising edge.
  task automatic drive(input logic r0, input logic [31:0] a0, input logic w0, input logic [31:0] d0,
                       input logic r1, input logic [31:0] a1, input logic w1, input logic [31:0] d1,
                       input logic rdy, input logic rst);
    @(posedge HCLK);
    #1;
    bus.M0_REQ = r0; bus.M0_HADDR = a0; bus.M0_HWRITE = w0; bus.M0_HWDATA = d0;
    bus.M1_REQ = r1; bus.M1_HADDR = a1; bus.M1_HWRITE = w1; bus.M1_HWDATA = d1;
    bus.HREADY = rdy;
    HRESET = rst;
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
  endtask

  task automatic test_reset();
    do_reset();
    // Reset held while both masters request with a stalled slave.
    drive(1, 32'h10, 1, 32'h1, 1, 32'h20, 1, 32'h2, 0, 1);
    sb.push_back(mk(0, 0, 0, 2'b00, 0, 0, 0));
    @(negedge HCLK);
    obs = sample(); ex = sb.pop_front(); checks++;
    if (obs !== ex) begin errors++; $display("FAIL reset_hold got %s want %s", fmt(obs), fmt(ex)); end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    sb.push_back(mk(0, 0, 1, 2'b00, 0, 0, 0));
    @(negedge HCLK);
    obs = sample(); ex = sb.pop_front(); checks++;
    if (obs !== ex) begin errors++; $display("FAIL reset_after got %s want %s", fmt(obs), fmt(ex)); end
  endtask

  task automatic test_single();
    logic [31:0] d0 = 32'h1111_2222;
    do_reset();
    for (int c = 0; c < 4; c++) begin
      case (c)
        0: begin drive(1, 32'h100, 1, d0, 0, 0, 0, 0, 1, 0); sb.push_back(mk(0, 0, 1, 2'b00, 0, 0, 0)); end
        1: begin drive(1, 32'h100, 1, d0, 0, 0, 0, 0, 1, 0); sb.push_back(mk(1, 0, 1, 2'b10, 1, 32'h100, 0)); end
        2: begin drive(0, 32'h100, 1, d0, 0, 0, 0, 0, 1, 0); sb.push_back(mk(1, 0, 1, 2'b00, 0, 0, d0)); end
        default: begin drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0); sb.push_back(mk(0, 0, 1, 2'b00, 0, 0, 0)); end
      endcase
      @(negedge HCLK);
      obs = sample(); ex = sb.pop_front(); checks++;
      if (obs !== ex) begin errors++; $display("FAIL single c%0d got %s want %s", c, fmt(obs), fmt(ex)); end
    end
  endtask

  task automatic test_hold();
    logic [31:0] d0 = 32'hD0D0_0000;
    logic [31:0] d1 = 32'hD1D1_1111;
    int ph, pph;
    do_reset();
    for (int c = 0; c < 19; c++) begin
      ph  = ((c - 1) / 4) % 2;
      pph = ((c - 2) / 4) % 2;
      if (c < 17) drive(1, 32'h1000, 1, d0, 1, 32'h2000, 0, d1, 1, 0);
      else        drive(0, 32'h1000, 1, d0, 0, 32'h2000, 0, d1, 1, 0);
      if (c == 0 || c == 18)
        sb.push_back(mk(0, 0, 1, 2'b00, 0, 0, 0));
      else if (c == 17)
        sb.push_back(mk(1, 0, 1, 2'b00, 0, 0, d1));
      else
        sb.push_back(mk(ph == 0, ph == 1, 1, 2'b10, ph == 0, (ph == 0) ? 32'h1000 : 32'h2000,
                        (c == 1) ? 32'd0 : ((pph == 0) ? d0 : d1)));
      @(negedge HCLK);
      obs = sample(); ex = sb.pop_front(); checks++;
      if (obs !== ex) begin errors++; $display("FAIL hold c%0d got %s want %s", c, fmt(obs), fmt(ex)); end
    end
  endtask

  task automatic test_handover();
    logic [31:0] da = 32'hA5A5_A5A5;
    logic [31:0] db = 32'h5A5A_5A5A;
    do_reset();
    for (int c = 0; c < 8; c++) begin
      if (c == 0) begin
        drive(1, 32'h300, 1, da, 0, 32'h200, 0, db, 1, 0);
        sb.push_back(mk(0, 0, 1, 2'b00, 0, 0, 0));
      end else if (c < 5) begin
        drive(1, 32'h300, 1, da, 1, 32'h200, 0, db, 1, 0);
        sb.push_back(mk(1, 0, 1, 2'b10, 1, 32'h300, (c == 1) ? 32'd0 : da));
      end else if (c == 5) begin
        drive(0, 32'h300, 1, da, 1, 32'h200, 0, db, 1, 0);
        sb.push_back(mk(0, 1, 1, 2'b10, 0, 32'h200, da));
      end else if (c == 6) begin
        drive(0, 32'h300, 1, da, 0, 32'h200, 0, db, 1, 0);
        sb.push_back(mk(0, 1, 1, 2'b00, 0, 0, db));
      end else begin
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        sb.push_back(mk(0, 0, 1, 2'b00, 0, 0, 0));
      end
      @(negedge HCLK);
      obs = sample(); ex = sb.pop_front(); checks++;
      if (obs !== ex) begin errors++; $display("FAIL handover c%0d got %s want %s", c, fmt(obs), fmt(ex)); end
    end
  endtask

  task automatic test_stall();
    logic [31:0] d0 = 32'hC0C0_C0C0;
    logic [31:0] d1 = 32'hB1B1_B1B1;
    do_reset();
    for (int c = 0; c < 10; c++) begin
      case (c)
        0: begin drive(0, 32'h500, 0, d0, 1, 32'h400, 1, d1, 1, 0); sb.push_back(mk(0, 0, 1, 2'b00, 0, 0, 0)); end
        1: begin drive(1, 32'h500, 0, d0, 1, 32'h400, 1, d1, 1, 0); sb.push_back(mk(0, 1, 1, 2'b10, 1, 32'h400, 0)); end
        2, 3, 4: begin
          drive(1, 32'h500, 0, d0, 1, 32'h400, 1, d1, 0, 0);
          sb.push_back(mk(0, 1, 0, 2'b10, 1, 32'h400, d1));
        end
        5: begin drive(1, 32'h500, 0, d0, 1, 32'h400, 1, d1, 1, 0); sb.push_back(mk(0, 1, 1, 2'b10, 1, 32'h400, d1)); end
        6: begin drive(1, 32'h500, 0, d0, 0, 32'h400, 1, d1, 1, 0); sb.push_back(mk(0, 1, 1, 2'b00, 0, 0, d1)); end
        7: begin drive(1, 32'h500, 0, d0, 0, 32'h400, 1, d1, 1, 0); sb.push_back(mk(1, 0, 1, 2'b10, 0, 32'h500, 0)); end
        8: begin drive(0, 32'h500, 0, d0, 0, 32'h400, 1, d1, 1, 0); sb.push_back(mk(1, 0, 1, 2'b00, 0, 0, d0)); end
        default: begin drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0); sb.push_back(mk(0, 0, 1, 2'b00, 0, 0, 0)); end
      endcase
      @(negedge HCLK);
      obs = sample(); ex = sb.pop_front(); checks++;
      if (obs !== ex) begin errors++; $display("FAIL stall c%0d got %s want %s", c, fmt(obs), fmt(ex)); end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d0 = 32'hE0E0_E0E0;
    logic [31:0] d1 = 32'hF1F1_F1F1;
    do_reset();
    for (int c = 0; c < 7; c++) begin
      case (c)
        0: begin drive(1, 32'h600, 1, d0, 0, 32'h700, 0, d1, 1, 0); sb.push_back(mk(0, 0, 1, 2'b00, 0, 0, 0)); end
        1: begin drive(1, 32'h600, 1, d0, 0, 32'h700, 0, d1, 1, 0); sb.push_back(mk(1, 0, 1, 2'b10, 1, 32'h600, 0)); end
        2: begin drive(1, 32'h600, 1, d0, 0, 32'h700, 0, d1, 0, 1); sb.push_back(mk(1, 0, 0, 2'b10, 1, 32'h600, d0)); end
        3: begin drive(1, 32'h600, 1, d0, 1, 32'h700, 0, d1, 1, 0); sb.push_back(mk(0, 0, 1, 2'b00, 0, 0, 0)); end
        4: begin drive(1, 32'h600, 1, d0, 1, 32'h700, 0, d1, 1, 0); sb.push_back(mk(1, 0, 1, 2'b10, 1, 32'h600, 0)); end
        5: begin drive(0, 32'h600, 1, d0, 0, 32'h700, 0, d1, 1, 0); sb.push_back(mk(1, 0, 1, 2'b00, 0, 0, d0)); end
        default: begin drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0); sb.push_back(mk(0, 0, 1, 2'b00, 0, 0, 0)); end
      endcase
      @(negedge HCLK);
      obs = sample(); ex = sb.pop_front(); checks++;
      if (obs !== ex) begin errors++; $display("FAIL reset_mid c%0d got %s want %s", c, fmt(obs), fmt(ex)); end
    end
  endtask

  initial begin
    HRESET = 1'b1;
    bus.M0_REQ = 0; bus.M0_HADDR = 0; bus.M0_HWRITE = 0; bus.M0_HWDATA = 0;
    bus.M1_REQ = 0; bus.M1_HADDR = 0; bus.M1_HWRITE = 0; bus.M1_HWDATA = 0;
    bus.HREADY = 1'b1;
    test_reset();
    test_single();
    test_hold();
    test_handover();
    test_stall();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
